// File: rtl/add12u_pkg.sv
// add12u_pkg: shared widths, mode enum, S1 payload and round-robin grant helper
package add12u_pkg;
  localparam int ADD_W = 12;
  localparam int SUM_W = 13;
  localparam int TAG_MAX = 3;
  typedef enum logic {
    MODE_EXACT  = 1'b0,
    MODE_APPROX = 1'b1
  } add_mode_e;
  typedef struct packed {
    logic [ADD_W-1:0]   a;
    logic [ADD_W-1:0]   b;
    logic [TAG_MAX-1:0] tag;
    add_mode_e          mode;
  } s1_t;
  // First valid requester after last, wrapping modulo n; one-hot or zero.
  function automatic logic [7:0] rr_grant(input logic [7:0] valid, input logic [2:0] last, input int n);
    logic [7:0] g;
    logic [2:0] idx;
    g = '0;
    for (int k = 1; k <= 8; k++) begin
      idx = 3'((int'(last) + k) % n);
      if (k <= n && g == '0 && valid[idx]) g[idx] = 1'b1;
    end
    return g;
  endfunction
endpackage

// File: rtl/add12u_core.sv
// add12u_core: combinational 12-bit adder, approximate (add12u_0LB) or exact sum
module add12u_core
  import add12u_pkg::*;
(
  input  logic [ADD_W-1:0] a,
  input  logic [ADD_W-1:0] b,
  input  add_mode_e        mode,
  output logic [SUM_W-1:0] sum
);
  logic [8:0]       hi;
  logic [SUM_W-1:0] approx;
  logic [SUM_W-1:0] exact;
  assign hi     = {1'b0, a[11:4]} + {1'b0, b[11:4]} + {8'd0, a[3]};
  assign approx = {hi, b[3], b[2], a[1], b[1]};
  assign exact  = {1'b0, a} + {1'b0, b};
  assign sum    = (mode == MODE_APPROX) ? approx : exact;
endmodule

// File: rtl/add12u_rr_share.sv
// add12u_rr_share: round-robin front end sharing one add12u core across NREQ requesters
module add12u_rr_share
  import add12u_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int TAGW = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*ADD_W-1:0] req_a,
  input  logic [NREQ*ADD_W-1:0] req_b,
  input  logic [NREQ-1:0]       req_approx,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [SUM_W-1:0]      res_sum,
  output logic [TAGW-1:0]       res_tag,
  output logic                  res_approx,
  output logic                  busy
);
  logic             s1_valid;
  s1_t              s1;
  logic [TAGW-1:0]  last;
  logic [NREQ-1:0]  grant;
  logic             s1_en;
  logic             s2_en;
  logic             hs;
  logic [TAGW-1:0]  gidx;
  logic [ADD_W-1:0] ga;
  logic [ADD_W-1:0] gb;
  logic             gm;
  logic [SUM_W-1:0] core_sum;
  assign grant     = NREQ'(rr_grant(8'(req_valid), 3'(last), NREQ));
  assign s2_en     = !res_valid | res_ready;
  assign s1_en     = !s1_valid | s2_en;
  assign req_ready = grant & {NREQ{s1_en}};
  assign hs        = |req_ready;
  assign busy      = s1_valid | res_valid;
  // Decode the one-hot grant into a tag and steer that requester's operands
  always_comb begin
    gidx = '0;
    ga   = '0;
    gb   = '0;
    gm   = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        gidx = TAGW'(i);
        ga   = req_a[ADD_W*i +: ADD_W];
        gb   = req_b[ADD_W*i +: ADD_W];
        gm   = req_approx[i];
      end
    end
  end
  // S1 captures the accepted request; the pointer moves only on a real handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1       <= '0;
      last     <= TAGW'(NREQ - 1);
    end else if (hs) begin
      s1_valid <= 1'b1;
      s1       <= '{a: ga, b: gb, tag: 3'(gidx), mode: add_mode_e'(gm)};
      last     <= gidx;
    end else if (s1_en) begin
      s1_valid <= 1'b0;
    end
  end
  add12u_core u_core (
    .a   (s1.a),
    .b   (s1.b),
    .mode(s1.mode),
    .sum (core_sum)
  );
  // S2 output register holds until downstream accepts
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_valid  <= 1'b0;
      res_sum    <= '0;
      res_tag    <= '0;
      res_approx <= 1'b0;
    end else if (s2_en) begin
      res_valid <= s1_valid;
      if (s1_valid) begin
        res_sum    <= core_sum;
        res_tag    <= TAGW'(s1.tag % NREQ);
        res_approx <= (s1.mode == MODE_APPROX);
      end
    end
  end
endmodule

// File: tb/tb_add12u_rr_share.sv
// tb_add12u_rr_share: directed and random checks with a cycle model and result scoreboard
module tb_add12u_rr_share;
  localparam int N = 4;
  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic [N-1:0]  req_valid;
  logic [N-1:0]  req_ready;
  logic [N*12-1:0] req_a;
  logic [N*12-1:0] req_b;
  logic [N-1:0]  req_approx;
  logic          res_valid;
  logic          res_ready;
  logic [12:0]   res_sum;
  logic [1:0]    res_tag;
  logic          res_approx;
  logic          busy;
  logic [N-1:0]  rv;
  logic [N-1:0]  rm;
  logic [11:0]   ra [N];
  logic [11:0]   rb [N];
  typedef struct {
    logic [12:0] sum;
    logic [1:0]  tag;
    logic        mode;
  } exp_t;
  exp_t sb[$];
  int   acc_q[$];
  int   checks = 0;
  int   errors = 0;
  int   seen = 0;
  int   m_last;
  logic m_s1v, m_rv, hold_v, hold_m;
  logic [12:0] hold_sum;
  logic [1:0]  hold_tag;

  add12u_rr_share #(.NREQ(N)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_approx(req_approx),
    .res_valid(res_valid), .res_ready(res_ready), .res_sum(res_sum),
    .res_tag(res_tag), .res_approx(res_approx), .busy(busy)
  );

  always #5 clk = ~clk;

  always_comb begin
    req_valid  = rv;
    req_approx = rm;
    for (int i = 0; i < N; i++) begin
      req_a[12*i +: 12] = ra[i];
      req_b[12*i +: 12] = rb[i];
    end
  end

  function automatic logic [12:0] ref_sum(logic [11:0] a, logic [11:0] b, logic m);
    int s;
    if (m) s = ((((int'(a) >> 4) + (int'(b) >> 4) + ((int'(a) >> 3) & 1)) << 4)
               | (int'(b) & 'hC) | (int'(a) & 2) | ((int'(b) >> 1) & 1));
    else s = int'(a) + int'(b);
    return 13'(s);
  endfunction

  function automatic logic [N-1:0] ref_grant(logic [N-1:0] v, int last);
    for (int k = 1; k <= N; k++) if (v[(last + k) % N]) return N'(1 << ((last + k) % N));
    return '0;
  endfunction

  // Cycle model: checks handshakes, occupancy and results at every falling edge
  always @(negedge clk) begin
    logic [N-1:0] g, er;
    logic s1en, s2en;
    exp_t e;
    int idx;
    if (!rst_n) begin
      m_last = N - 1; m_s1v = 0; m_rv = 0; hold_v = 0;
      sb.delete();
      checks++;
      assert (res_valid === 1'b0 && busy === 1'b0 && req_ready === '0) else begin
        errors++;
        $error("FAIL reset_state observed rv=%b busy=%b rdy=%b expected 0 0 0", res_valid, busy, req_ready);
      end
    end else begin
      s2en = !m_rv || res_ready;
      s1en = !m_s1v || s2en;
      g = ref_grant(rv, m_last);
      er = s1en ? g : '0;
      checks++;
      assert (req_ready === er) else begin
        errors++; $error("FAIL req_ready observed %b expected %b", req_ready, er);
      end
      checks++;
      assert (res_valid === m_rv && busy === (m_s1v | m_rv)) else begin
        errors++; $error("FAIL occupancy observed rv=%b busy=%b expected rv=%b busy=%b", res_valid, busy, m_rv, m_s1v | m_rv);
      end
      if (hold_v) begin
        checks++;
        assert (res_sum === hold_sum && res_tag === hold_tag && res_approx === hold_m) else begin
          errors++; $error("FAIL hold_stable observed %h/%0d/%b expected %h/%0d/%b", res_sum, res_tag, res_approx, hold_sum, hold_tag, hold_m);
        end
      end
      if (m_rv && res_ready) begin
        checks++;
        if (sb.size() == 0) begin
          errors++; $error("FAIL sb_empty observed result %h with no expected entry", res_sum);
        end else begin
          e = sb.pop_front();
          assert (res_sum === e.sum && res_tag === e.tag && res_approx === e.mode) else begin
            errors++; $error("FAIL result observed %h/%0d/%b expected %h/%0d/%b", res_sum, res_tag, res_approx, e.sum, e.tag, e.mode);
          end
        end
      end
      hold_v = m_rv && !res_ready;
      hold_sum = res_sum; hold_tag = res_tag; hold_m = res_approx;
      if (|er) begin
        idx = $clog2(er);
        e.sum = ref_sum(ra[idx], rb[idx], rm[idx]);
        e.tag = 2'(idx);
        e.mode = rm[idx];
        sb.push_back(e);
        acc_q.push_back(idx);
        m_last = idx;
      end
      m_rv = s2en ? m_s1v : m_rv;
      m_s1v = (|er) ? 1'b1 : (s1en ? 1'b0 : m_s1v);
    end
  end

  task automatic step(input bit drop);
    @(posedge clk);
    #1;
    if (acc_q.size() != seen) begin
      if (drop) rv[acc_q[$]] = 1'b0;
      seen = acc_q.size();
    end
  endtask

  task automatic send(input int i, input logic [11:0] a, input logic [11:0] b, input logic m);
    int n0;
    ra[i] = a; rb[i] = b; rm[i] = m; rv[i] = 1'b1;
    n0 = acc_q.size();
    for (int k = 0; k < 50 && acc_q.size() == n0; k++) step(1);
    checks++;
    assert (acc_q.size() != n0) else begin
      errors++; rv[i] = 1'b0; $error("FAIL accept_timeout observed no handshake on %0d expected one", i);
    end
  endtask

  task automatic chk_res(input string name, input logic [12:0] s, input logic [1:0] t, input logic m);
    checks++;
    assert (res_valid === 1'b1 && res_sum === s && res_tag === t && res_approx === m) else begin
      errors++; $error("FAIL %s observed v=%b %h/%0d/%b expected v=1 %h/%0d/%b", name, res_valid, res_sum, res_tag, res_approx, s, t, m);
    end
  endtask

  initial begin
    int n0;
    rv = '0; rm = '0; res_ready = 1'b1;
    for (int i = 0; i < N; i++) begin ra[i] = '0; rb[i] = '0; end
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    assert (res_sum === 13'h0 && res_tag === 2'd0 && res_approx === 1'b0) else begin
      errors++; $error("FAIL reset_data observed %h/%0d/%b expected 0/0/0", res_sum, res_tag, res_approx);
    end
    rst_n = 1'b1;
    send(0, 12'h00F, 12'h001, 1'b1); step(1); chk_res("t1_approx", 13'h012, 2'd0, 1'b1);
    send(0, 12'h00F, 12'h001, 1'b0); step(1); chk_res("t2_exact", 13'h010, 2'd0, 1'b0);
    send(0, 12'hFFF, 12'hFFF, 1'b1); step(1); chk_res("t2_max_approx", 13'h1FFF, 2'd0, 1'b1);
    send(0, 12'hFFF, 12'hFFF, 1'b0); step(1); chk_res("t2_max_exact", 13'h1FFE, 2'd0, 1'b0);
    step(1);
    for (int i = 0; i < N; i++) begin ra[i] = 12'(100 * i + 7); rb[i] = 12'(3 * i); rm[i] = i[0]; end
    rv = '1;
    n0 = acc_q.size();
    for (int j = 0; j < 8; j++) begin
      step(0);
      checks++;
      assert (acc_q.size() == n0 + j + 1 && acc_q[$] == (j + 1) % N) else begin
        errors++; $error("FAIL rr_order observed cnt=%0d tag=%0d expected cnt=%0d tag=%0d", acc_q.size() - n0, acc_q[$], j + 1, (j + 1) % N);
      end
    end
    rv = '0;
    repeat (3) step(1);
    res_ready = 1'b0;
    rv = 4'b0111;
    n0 = acc_q.size();
    repeat (6) step(1);
    checks++;
    assert (acc_q.size() - n0 == 2 && req_ready === '0) else begin
      errors++; $error("FAIL bp_fill observed accepted=%0d rdy=%b expected 2 0000", acc_q.size() - n0, req_ready);
    end
    res_ready = 1'b1;
    for (int k = 0; k < 20 && rv != '0; k++) step(1);
    checks++;
    assert (acc_q.size() - n0 == 3) else begin
      errors++; $error("FAIL bp_drain observed accepted=%0d expected 3", acc_q.size() - n0);
    end
    repeat (3) step(1);
    res_ready = 1'b0;
    send(2, 12'h123, 12'h456, 1'b0);
    send(2, 12'h0A5, 12'h05A, 1'b1);
    rv[1] = 1'b1; rv[3] = 1'b1;
    n0 = acc_q.size();
    repeat (3) step(1);
    checks++;
    assert (acc_q.size() == n0 && req_ready === '0) else begin
      errors++; $error("FAIL stall_grant observed accepted=%0d rdy=%b expected 0 0000", acc_q.size() - n0, req_ready);
    end
    res_ready = 1'b1;
    for (int k = 0; k < 20 && acc_q.size() < n0 + 2; k++) step(1);
    checks++;
    assert (acc_q.size() >= n0 + 2 && acc_q[n0] == 3 && acc_q[n0 + 1] == 1) else begin
      errors++; $error("FAIL stall_order observed cnt=%0d expected order 3 then 1", acc_q.size() - n0);
    end
    repeat (3) step(1);
    res_ready = 1'b0;
    send(0, 12'h111, 12'h222, 1'b0);
    send(1, 12'h333, 12'h444, 1'b1);
    #1 rst_n = 1'b0;
    #1;
    checks++;
    assert (res_valid === 1'b0 && busy === 1'b0) else begin
      errors++; $error("FAIL async_reset observed rv=%b busy=%b expected 0 0", res_valid, busy);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    res_ready = 1'b1;
    rv = '1;
    n0 = acc_q.size();
    step(1);
    checks++;
    assert (acc_q.size() == n0 + 1 && acc_q[$] == 0) else begin
      errors++; $error("FAIL post_reset_grant observed cnt=%0d expected first grant to 0", acc_q.size() - n0);
    end
    rv = '0;
    repeat (3) step(1);
    for (int c = 0; c < 10000; c++) begin
      step(1);
      res_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < N; i++) begin
        if (!rv[i] && $urandom_range(0, 2) == 0) begin
          ra[i] = 12'($urandom); rb[i] = 12'($urandom); rm[i] = 1'($urandom); rv[i] = 1'b1;
        end
      end
    end
    rv = '0;
    res_ready = 1'b1;
    repeat (4) step(1);
    checks++;
    assert (sb.size() == 0 && busy === 1'b0) else begin
      errors++; $error("FAIL final_drain observed pending=%0d busy=%b expected 0 0", sb.size(), busy);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
